// File: rtl/rv32_pkg.sv
// Shared definitions for the RV32IM next-PC sequencer: FSM state
// encoding, trap cause codes and default boot/trap vectors.
package rv32_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_HALT  = 2'd3
    } seq_state_t;

    localparam logic [1:0] CAUSE_MISALIGN = 2'd0;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd1;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0100;

endpackage

// File: rtl/stall_watchdog.sv
// Stall watchdog: counts cycles a multi-cycle unit holds the PC.
// Ports: clk, rst (sync, active-high), clear, enable -> expired.
// expired is high while the count equals STALL_TIMEOUT-1.
module stall_watchdog #(
    parameter int STALL_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(STALL_TIMEOUT);
    localparam logic [W-1:0] LAST = W'(STALL_TIMEOUT - 1);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + W'(1);
        end
    end

    assign expired = (r_count == LAST);

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller for the single-cycle RV32IM core.
// Inputs: clk, rst, curr_addr, branch/jump/jalr controls, stall and
// halt requests. Outputs: next_addr, trap_valid/cause/epc, halted,
// instret (64-bit retired-instruction count).
module pc_sequencer
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_VEC     = DEF_RESET_VEC,
    parameter logic [31:0] TRAP_VEC      = DEF_TRAP_VEC,
    parameter int          STALL_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] curr_addr,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        jalr,
    input  logic [31:0] jalr_target,
    input  logic        stall_req,
    input  logic        stall_done,
    input  logic        halt_req,
    output logic [31:0] next_addr,
    output logic        trap_valid,
    output logic [1:0]  trap_cause,
    output logic [31:0] trap_epc,
    output logic        halted,
    output logic [63:0] instret
);

    seq_state_t  r_state;
    seq_state_t  w_state_nxt;
    logic        r_trap_valid;
    logic [1:0]  r_trap_cause;
    logic [31:0] r_trap_epc;
    logic [63:0] r_instret;

    logic [31:0] w_next_addr;
    logic [31:0] w_target;
    logic        w_redirect;
    logic        w_misalign;
    logic        w_resolve;
    logic        w_trap;
    logic [1:0]  w_cause;
    logic        w_retire;
    logic        w_wd_clear;
    logic        w_wd_en;
    logic        w_wd_expired;

    stall_watchdog #(
        .STALL_TIMEOUT(STALL_TIMEOUT)
    ) u_wd (
        .clk    (clk),
        .rst    (rst),
        .clear  (w_wd_clear),
        .enable (w_wd_en),
        .expired(w_wd_expired)
    );

    // Target mux, first match wins; JALR clears bit 0.
    always_comb begin
        w_target = curr_addr + 32'd4;
        if (jalr) begin
            w_target = {jalr_target[31:1], 1'b0};
        end else if (jump) begin
            w_target = jump_target;
        end else if (branch_taken) begin
            w_target = branch_target;
        end
    end

    assign w_redirect = jalr | jump | branch_taken;
    assign w_misalign = w_redirect & w_target[1];

    always_comb begin
        w_state_nxt = r_state;
        w_next_addr = curr_addr;
        w_trap      = 1'b0;
        w_cause     = CAUSE_MISALIGN;
        w_retire    = 1'b0;
        w_wd_clear  = 1'b0;
        w_wd_en     = 1'b0;
        w_resolve   = 1'b0;
        unique case (r_state)
            ST_BOOT: begin
                w_next_addr = RESET_VEC;
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (stall_req && !stall_done) begin
                    // Watchdog goes 0 -> 1 on the stall entry edge.
                    w_wd_en     = 1'b1;
                    w_state_nxt = ST_STALL;
                end else begin
                    w_resolve = 1'b1;
                end
            end
            ST_STALL: begin
                if (stall_done) begin
                    // Done wins over a same-cycle timeout.
                    w_resolve  = 1'b1;
                    w_wd_clear = 1'b1;
                end else if (w_wd_expired) begin
                    w_next_addr = TRAP_VEC;
                    w_trap      = 1'b1;
                    w_cause     = CAUSE_TIMEOUT;
                    w_wd_clear  = 1'b1;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_wd_en = 1'b1;
                end
            end
            ST_HALT: begin
                w_next_addr = curr_addr;
            end
            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase

        if (w_resolve) begin
            if (halt_req) begin
                w_next_addr = curr_addr;
                w_retire    = 1'b1;
                w_state_nxt = ST_HALT;
            end else if (w_misalign) begin
                w_next_addr = TRAP_VEC;
                w_trap      = 1'b1;
                w_cause     = CAUSE_MISALIGN;
                w_state_nxt = ST_RUN;
            end else begin
                w_next_addr = w_target;
                w_retire    = 1'b1;
                w_state_nxt = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_BOOT;
            r_trap_valid <= 1'b0;
            r_trap_cause <= CAUSE_MISALIGN;
            r_trap_epc   <= '0;
            r_instret    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_trap_valid <= w_trap;
            if (w_trap) begin
                r_trap_cause <= w_cause;
                r_trap_epc   <= curr_addr;
            end
            if (w_retire) begin
                r_instret <= r_instret + 64'd1;
            end
        end
    end

    assign next_addr  = w_next_addr;
    assign trap_valid = r_trap_valid;
    assign trap_cause = r_trap_cause;
    assign trap_epc   = r_trap_epc;
    assign halted     = (r_state == ST_HALT);
    assign instret    = r_instret;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer: boot, target select,
// misaligned trap, stall/watchdog, halt and reset recovery.
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic [31:0] curr_addr;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        jalr;
    logic [31:0] jalr_target;
    logic        stall_req;
    logic        stall_req4;
    logic        stall_done;
    logic        halt_req;

    logic [31:0] next_addr;
    logic        trap_valid;
    logic [1:0]  trap_cause;
    logic [31:0] trap_epc;
    logic        halted;
    logic [63:0] instret;

    logic [31:0] next_addr4;
    logic        trap_valid4;
    logic [1:0]  trap_cause4;
    logic [31:0] trap_epc4;
    logic        halted4;
    logic [63:0] instret4;

    int errors;
    int checks;
    longint unsigned exp_ir;

    pc_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .curr_addr    (curr_addr),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .jalr         (jalr),
        .jalr_target  (jalr_target),
        .stall_req    (stall_req),
        .stall_done   (stall_done),
        .halt_req     (halt_req),
        .next_addr    (next_addr),
        .trap_valid   (trap_valid),
        .trap_cause   (trap_cause),
        .trap_epc     (trap_epc),
        .halted       (halted),
        .instret      (instret)
    );

    pc_sequencer #(
        .STALL_TIMEOUT(4)
    ) dut4 (
        .clk          (clk),
        .rst          (rst),
        .curr_addr    (curr_addr),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .jalr         (jalr),
        .jalr_target  (jalr_target),
        .stall_req    (stall_req4),
        .stall_done   (stall_done),
        .halt_req     (halt_req),
        .next_addr    (next_addr4),
        .trap_valid   (trap_valid4),
        .trap_cause   (trap_cause4),
        .trap_epc     (trap_epc4),
        .halted       (halted4),
        .instret      (instret4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_ctl();
        branch_taken  = 1'b0;
        branch_target = '0;
        jump          = 1'b0;
        jump_target   = '0;
        jalr          = 1'b0;
        jalr_target   = '0;
        stall_req     = 1'b0;
        stall_req4    = 1'b0;
        stall_done    = 1'b0;
        halt_req      = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        curr_addr = 32'h40;
        clr_ctl();
        tick();
        tick();
        checks++;
        if (next_addr !== 32'h0) begin
            errors++;
            $display("FAIL rst_next got=%h exp=%h", next_addr, 32'h0);
        end
        checks++;
        if (trap_valid !== 1'b0 || trap_cause !== 2'd0 ||
            trap_epc !== 32'h0) begin
            errors++;
            $display("FAIL rst_trap got=%b/%0d/%h exp=0/0/0",
                     trap_valid, trap_cause, trap_epc);
        end
        checks++;
        if (halted !== 1'b0 || instret !== 64'd0) begin
            errors++;
            $display("FAIL rst_hi got=%b/%0d exp=0/0",
                     halted, instret);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (next_addr !== 32'h0) begin
            errors++;
            $display("FAIL boot_next got=%h exp=%h", next_addr, 32'h0);
        end
        tick();
        curr_addr = 32'h8;
        #1;
        checks++;
        if (next_addr !== 32'hC) begin
            errors++;
            $display("FAIL boot_to_run got=%h exp=%h", next_addr, 32'hC);
        end
        exp_ir = 0;
        checks++;
        if (instret !== exp_ir) begin
            errors++;
            $display("FAIL boot_instret got=%0d exp=%0d", instret, exp_ir);
        end
    endtask

    task automatic test_run();
        curr_addr = 32'h8;
        #1;
        checks++;
        if (next_addr !== 32'hC) begin
            errors++;
            $display("FAIL seq got=%h exp=%h", next_addr, 32'hC);
        end
        tick();
        exp_ir++;
        branch_taken  = 1'b1;
        branch_target = 32'h20;
        #1;
        checks++;
        if (next_addr !== 32'h20) begin
            errors++;
            $display("FAIL branch got=%h exp=%h", next_addr, 32'h20);
        end
        tick();
        exp_ir++;
        jalr        = 1'b1;
        jalr_target = 32'h25;
        jump        = 1'b1;
        jump_target = 32'h40;
        #1;
        checks++;
        if (next_addr !== 32'h24) begin
            errors++;
            $display("FAIL jalr got=%h exp=%h", next_addr, 32'h24);
        end
        tick();
        exp_ir++;
        jalr        = 1'b0;
        jump_target = 32'h44;
        #1;
        checks++;
        if (next_addr !== 32'h44) begin
            errors++;
            $display("FAIL jump_prio got=%h exp=%h", next_addr, 32'h44);
        end
        tick();
        exp_ir++;
        clr_ctl();
        curr_addr = 32'hFFFF_FFFC;
        #1;
        checks++;
        if (next_addr !== 32'h0) begin
            errors++;
            $display("FAIL wrap got=%h exp=%h", next_addr, 32'h0);
        end
        tick();
        exp_ir++;
        checks++;
        if (instret !== exp_ir) begin
            errors++;
            $display("FAIL run_instret got=%0d exp=%0d", instret, exp_ir);
        end
    endtask

    task automatic test_misalign();
        curr_addr   = 32'h10;
        jump        = 1'b1;
        jump_target = 32'h22;
        #1;
        checks++;
        if (next_addr !== 32'h100) begin
            errors++;
            $display("FAIL mis_next got=%h exp=%h", next_addr, 32'h100);
        end
        tick();
        checks++;
        if (trap_valid !== 1'b1 || trap_cause !== 2'd0 ||
            trap_epc !== 32'h10) begin
            errors++;
            $display("FAIL mis_trap got=%b/%0d/%h exp=1/0/10",
                     trap_valid, trap_cause, trap_epc);
        end
        checks++;
        if (instret !== exp_ir) begin
            errors++;
            $display("FAIL mis_instret got=%0d exp=%0d", instret, exp_ir);
        end
        clr_ctl();
        curr_addr = 32'h100;
        tick();
        exp_ir++;
        checks++;
        if (trap_valid !== 1'b0 || trap_epc !== 32'h10) begin
            errors++;
            $display("FAIL mis_pulse got=%b/%h exp=0/10",
                     trap_valid, trap_epc);
        end
    endtask

    task automatic test_stall();
        curr_addr = 32'h30;
        stall_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (next_addr !== 32'h30) begin
                errors++;
                $display("FAIL stall_hold%0d got=%h exp=%h",
                         i, next_addr, 32'h30);
            end
            tick();
        end
        checks++;
        if (instret !== exp_ir) begin
            errors++;
            $display("FAIL stall_ir got=%0d exp=%0d", instret, exp_ir);
        end
        stall_done = 1'b1;
        #1;
        checks++;
        if (next_addr !== 32'h34) begin
            errors++;
            $display("FAIL stall_done got=%h exp=%h", next_addr, 32'h34);
        end
        tick();
        exp_ir++;
        checks++;
        if (instret !== exp_ir) begin
            errors++;
            $display("FAIL stall_ret got=%0d exp=%0d", instret, exp_ir);
        end
        stall_req  = 1'b0;
        stall_done = 1'b0;
        curr_addr  = 32'h34;
        #1;
        checks++;
        if (next_addr !== 32'h38) begin
            errors++;
            $display("FAIL stall_exit got=%h exp=%h", next_addr, 32'h38);
        end
        tick();
        exp_ir++;
        stall_req     = 1'b1;
        stall_done    = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h80;
        curr_addr     = 32'h38;
        #1;
        checks++;
        if (next_addr !== 32'h80) begin
            errors++;
            $display("FAIL req_done got=%h exp=%h", next_addr, 32'h80);
        end
        tick();
        exp_ir++;
        clr_ctl();
        checks++;
        if (instret !== exp_ir) begin
            errors++;
            $display("FAIL req_done_ir got=%0d exp=%0d", instret, exp_ir);
        end
    endtask

    task automatic test_timeout();
        curr_addr  = 32'h60;
        stall_req4 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (next_addr4 !== 32'h60) begin
                errors++;
                $display("FAIL wd_hold%0d got=%h exp=%h",
                         i, next_addr4, 32'h60);
            end
            tick();
            exp_ir++;
        end
        #1;
        checks++;
        if (next_addr4 !== 32'h100) begin
            errors++;
            $display("FAIL wd_trap got=%h exp=%h", next_addr4, 32'h100);
        end
        tick();
        exp_ir++;
        checks++;
        if (trap_valid4 !== 1'b1 || trap_cause4 !== 2'd1 ||
            trap_epc4 !== 32'h60) begin
            errors++;
            $display("FAIL wd_out got=%b/%0d/%h exp=1/1/60",
                     trap_valid4, trap_cause4, trap_epc4);
        end
        curr_addr = 32'h64;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_ir++;
        end
        stall_done = 1'b1;
        #1;
        checks++;
        if (next_addr4 !== 32'h68) begin
            errors++;
            $display("FAIL wd_done_wins got=%h exp=%h", next_addr4, 32'h68);
        end
        tick();
        exp_ir++;
        checks++;
        if (trap_valid4 !== 1'b0 || trap_cause4 !== 2'd1) begin
            errors++;
            $display("FAIL wd_after got=%b/%0d exp=0/1",
                     trap_valid4, trap_cause4);
        end
        clr_ctl();
        checks++;
        if (instret !== exp_ir) begin
            errors++;
            $display("FAIL wd_main_ir got=%0d exp=%0d", instret, exp_ir);
        end
    endtask

    task automatic test_halt();
        curr_addr = 32'h50;
        halt_req  = 1'b1;
        #1;
        checks++;
        if (next_addr !== 32'h50) begin
            errors++;
            $display("FAIL halt_next got=%h exp=%h", next_addr, 32'h50);
        end
        tick();
        exp_ir++;
        checks++;
        if (halted !== 1'b1 || instret !== exp_ir) begin
            errors++;
            $display("FAIL halt_enter got=%b/%0d exp=1/%0d",
                     halted, instret, exp_ir);
        end
        halt_req      = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'h80;
        jump          = 1'b1;
        jump_target   = 32'h22;
        #1;
        checks++;
        if (next_addr !== 32'h50) begin
            errors++;
            $display("FAIL halt_stuck got=%h exp=%h", next_addr, 32'h50);
        end
        tick();
        checks++;
        if (halted !== 1'b1 || instret !== exp_ir ||
            trap_valid !== 1'b0) begin
            errors++;
            $display("FAIL halt_hold got=%b/%0d/%b exp=1/%0d/0",
                     halted, instret, trap_valid, exp_ir);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clr_ctl();
        #1;
        checks++;
        if (halted !== 1'b0 || next_addr !== 32'h0 ||
            instret !== 64'd0) begin
            errors++;
            $display("FAIL halt_rst got=%b/%h/%0d exp=0/0/0",
                     halted, next_addr, instret);
        end
        tick();
        curr_addr = 32'h70;
        stall_req = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clr_ctl();
        #1;
        checks++;
        if (next_addr !== 32'h0) begin
            errors++;
            $display("FAIL stall_rst got=%h exp=%h", next_addr, 32'h0);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        exp_ir = 0;
        test_reset();
        test_run();
        test_misalign();
        test_stall();
        test_timeout();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
